// File: rtl/path_id_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : path_id_decoder_if
// Description : Handshake bundle for path_id_decoder. The leaf-side
//               valid/ready/value and the result-side valid/ready/root/path/
//               err travel together. The DUT uses the slave modport and the
//               driving agent uses the master modport.
// Signals     : in_valid   leaf offered (master -> slave)
//               in_ready   block can take a leaf (slave -> master)
//               in_value   32-bit unsigned leaf value
//               out_valid  decode result available
//               out_ready  result consumed downstream
//               out_root   recovered root value
//               out_path   branch selects, bit 0 innermost .. bit 3 outermost
//               out_err    leaf not reachable from any root
// Revision    : 1.0  initial release
// ============================================================================
interface path_id_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_root;
    logic [3:0]  out_path;
    logic        out_err;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_root, out_path, out_err
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_root, out_path, out_err
    );
endinterface
`default_nettype wire

// File: rtl/path_id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : path_id_decoder
// Description : Inverts the four-level instance-value encoding
//               v = 4v+s3, v = 4v+s2, v = 3v+s1, v = 2v+s0 (outermost first).
//               A leaf is peeled one level per cycle (divide by 2, 3, 4, 4);
//               remainder bit 0 of each step becomes the branch select and a
//               remainder above 1 flags the leaf as unreachable.
// Ports       : clk   rising-edge clock
//               rst   synchronous active-high reset
//               bus   path_id_decoder_if.slave (leaf in, result out)
// Revision    : 1.0  initial release
// ============================================================================
module path_id_decoder (
    input wire logic          clk,
    input wire logic          rst,
    path_id_decoder_if.slave  bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_S0   = 3'd1;
    localparam logic [2:0] c_S1   = 3'd2;
    localparam logic [2:0] c_S2   = 3'd3;
    localparam logic [2:0] c_S3   = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_work;
    logic [2:0]  r_path;      // selects from S0..S2; S3's select goes straight to the output
    logic        r_err;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_root;
    logic [3:0]  r_out_path;
    logic        r_out_err;

    logic [31:0] w_q3;
    logic [1:0]  w_rem3;
    logic [31:0] w_quot;
    logic [1:0]  w_rem;

    // Divide-by-3 step. The remainder is 0..2, so it is fully determined by
    // the low two bits of (dividend - 3*quotient).
    assign w_q3   = r_work / 32'd3;
    assign w_rem3 = r_work[1:0] - (w_q3[1:0] + {w_q3[0], 1'b0});

    always_comb begin
        w_quot = r_work;
        w_rem  = 2'd0;
        case (r_state)
            c_S0: begin
                w_quot = {1'b0, r_work[31:1]};
                w_rem  = {1'b0, r_work[0]};
            end
            c_S1: begin
                w_quot = w_q3;
                w_rem  = w_rem3;
            end
            c_S2, c_S3: begin
                w_quot = {2'b00, r_work[31:2]};
                w_rem  = r_work[1:0];
            end
            default: begin
                w_quot = r_work;
                w_rem  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_work      <= 32'd0;
            r_path      <= 3'd0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_root      <= 32'd0;
            r_out_path  <= 4'd0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_work     <= bus.in_value;
                        r_path     <= 3'd0;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_S0;
                    end
                end
                c_S0: begin
                    r_work    <= w_quot;
                    r_path[0] <= w_rem[0];
                    r_err     <= r_err | w_rem[1];
                    r_state   <= c_S1;
                end
                c_S1: begin
                    r_work    <= w_quot;
                    r_path[1] <= w_rem[0];
                    r_err     <= r_err | w_rem[1];
                    r_state   <= c_S2;
                end
                c_S2: begin
                    r_work    <= w_quot;
                    r_path[2] <= w_rem[0];
                    r_err     <= r_err | w_rem[1];
                    r_state   <= c_S3;
                end
                c_S3: begin
                    // Result registers are only written here, so they keep
                    // the last result through IDLE and the next decode.
                    r_root     <= w_quot;
                    r_out_path <= {w_rem[0], r_path};
                    r_out_err  <= r_err | w_rem[1];
                    r_state    <= c_DONE;
                end
                c_DONE: begin
                    // out_valid is a registered output of DONE and trails DONE
                    // entry by one cycle; only a presented result can be consumed.
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_root  = r_root;
    assign bus.out_path  = r_out_path;
    assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_path_id_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_path_id_decoder
// Description : Scoreboard bench for path_id_decoder. The driver pushes the
//               expected result of every accepted leaf; a negedge monitor pops
//               and compares when out_valid rises, then watches the held
//               outputs until consumed. Random leaves are predicted with a
//               mixed-radix (2,3,4,4) digit expansion of the leaf.
// Revision    : 1.0  initial release
// ============================================================================
module tb_path_id_decoder;

    typedef struct {
        logic [31:0] root;
        logic [3:0]  path;
        logic        err;
        int          acc_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    logic        prev_valid;
    logic [31:0] held_root;
    logic [3:0]  held_path;
    logic        held_err;

    path_id_decoder_if bus ();

    path_id_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Leaf = ((root*4 + s3)*4 + s2)*3*2 + s1*2 + s0 read as mixed radix
    // digits; a digit above 1 means no select can have produced it.
    function automatic exp_t model(input logic [31:0] leaf);
        exp_t e;
        longint unsigned v, d0, d1, d2, d3;
        v  = longint'(leaf);
        d0 = v % 2;
        d1 = (v / 2) % 3;
        d2 = (v / 6) % 4;
        d3 = (v / 24) % 4;
        e.root     = 32'(v / 96);
        e.path     = {d3[0], d2[0], d1[0], d0[0]};
        e.err      = (d1 > 1) || (d2 > 1) || (d3 > 1);
        e.acc_edge = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a leaf and record its expected result at the accepting edge.
    task automatic send(input logic [31:0] leaf, input exp_t e_in);
        exp_t e;
        e = e_in;
        bus.in_valid = 1'b1;
        bus.in_value = leaf;
        for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e.acc_edge = cyc + 1;
        exp_q.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.in_value = $urandom;
    endtask

    // Wait for the result, stall it for 'hold' cycles with junk leaf pulses,
    // then consume it.
    task automatic collect(input int hold, input logic early_ready);
        bus.out_ready = early_ready;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            bus.out_ready = 1'b0;
            return;
        end
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_value = $urandom;
                tick();
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("in_ready_after_consume", 32'(bus.in_ready), 32'd1);
        check("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
    endtask

    function automatic exp_t mk(input logic [31:0] root, input logic [3:0] path, input logic err);
        exp_t e;
        e.root = root; e.path = path; e.err = err; e.acc_edge = 0;
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_root"},  bus.out_root,       32'd0);
        check({tag, "_out_path"},  32'(bus.out_path),  32'd0);
        check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
    endtask

    // Monitor: compare on the rising of out_valid, then stability while held.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("latency_edge", 32'(cyc), 32'(e.acc_edge + 5));
                    check("out_root", bus.out_root, e.root);
                    check("out_path", 32'(bus.out_path), 32'(e.path));
                    check("out_err", 32'(bus.out_err), 32'(e.err));
                end
                held_root = bus.out_root;
                held_path = bus.out_path;
                held_err  = bus.out_err;
            end else begin
                check("hold_root", bus.out_root, held_root);
                check("hold_path", 32'(bus.out_path), 32'(held_path));
                check("hold_err", 32'(bus.out_err), 32'(held_err));
            end
            check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        end
        prev_valid = bus.out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] leaf;
        int          kind;
        n_checks = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;       // offered during reset: must not be taken
        bus.in_value  = 32'd33;
        bus.out_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Directed cases, first one accepted in the first cycle out of reset.
        send(32'd33, mk(32'd0, 4'b1111, 1'b0));
        collect(0, 1'b0);
        send(32'd96, mk(32'd1, 4'b0000, 1'b0));
        collect(1, 1'b1);
        send(32'd2, mk(32'd0, 4'b0010, 1'b0));
        collect(0, 1'b1);
        send(32'd4, mk(32'd0, 4'b0000, 1'b1));
        collect(2, 1'b0);
        send(32'hFFFF_FFFF, mk(32'd44739242, 4'b0011, 1'b1));
        collect(0, 1'b0);

        // Long stall with ignored leaf pulses.
        send(32'd33, mk(32'd0, 4'b1111, 1'b0));
        collect(10, 1'b0);

        // Reset while the decode sits in S2: in-flight result is discarded.
        send(32'd96, mk(32'd1, 4'b0000, 1'b0));
        tick(); tick();               // now in S2
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_in_s2");
        send(32'd2, mk(32'd0, 4'b0010, 1'b0));
        collect(0, 1'b0);

        // Reset wins over a consume in the same cycle.
        send(32'd33, mk(32'd0, 4'b1111, 1'b0));
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        check_reset_outputs("rst_vs_consume");

        // Randomized leaves.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                leaf = 32'($urandom_range(0, 300));
            end else if (kind == 1) begin
                leaf = ((((32'($urandom_range(0, 100000)) * 4 + 32'($urandom_range(0, 1))) * 4
                        + 32'($urandom_range(0, 1))) * 3 + 32'($urandom_range(0, 1))) * 2)
                        + 32'($urandom_range(0, 1));
            end else begin
                leaf = $urandom;
            end
            send(leaf, model(leaf));
            collect(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        tick(); tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/path_id_decoder.md
PATH_ID_DECODER -- requirements
Module: path_id_decoder

Interface
REQ-001 The block SHALL be a single-clock design, clock `clk`, with reset `rst` synchronous and active-high.
REQ-002 Port `clk` SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock for all state.
REQ-003 Port `rst` SHALL be an input, 1 bit wide, and SHALL be the synchronous active-high reset.
REQ-004 Port `in_valid` SHALL be an input, 1 bit wide, and SHALL mark a leaf value as offered.
REQ-005 Port `in_ready` SHALL be an output, 1 bit wide, and SHALL mark the block as able to accept a leaf value.
REQ-006 Port `in_value` SHALL be an input, 32 bits wide, carrying the unsigned leaf value.
REQ-007 Port `out_valid` SHALL be an output, 1 bit wide, and SHALL mark a decode result as available.
REQ-008 Port `out_ready` SHALL be an input, 1 bit wide, and SHALL mark the result as consumed by the downstream.
REQ-009 Port `out_root` SHALL be an output, 32 bits wide, carrying the recovered root value.
REQ-010 Port `out_path` SHALL be an output, 4 bits wide, carrying the branch selects; bit 0 is the innermost level and bit 3 is the outermost level.
REQ-011 Port `out_err` SHALL be an output, 1 bit wide, and SHALL be set when the leaf value is not reachable from any root.

Function
REQ-012 The block SHALL invert the four-level instance-value encoding.
- Encoding, outermost to innermost: v = 4*v+s3, v = 4*v+s2, v = 3*v+s1, v = 2*v+s0.
- Each select s is 0 (branch x1) or 1 (branch x2).
REQ-013 The FSM states SHALL be IDLE, S0, S1, S2, S3 and DONE.
REQ-014 In IDLE, `in_ready` SHALL be 1; in every other state it SHALL be 0.
REQ-015 A handshake on `in_valid` and `in_ready` both high SHALL:
- load `in_value` into the working register;
- clear the path and error registers;
- move the FSM to S0.
REQ-016 `in_valid` asserted outside IDLE SHALL be ignored, with no state change.
REQ-017 Each of S0..S3 SHALL take exactly one cycle and perform one division.
- Divisors are 2, 3, 4 and 4 respectively.
- The quotient replaces the working register.
- Remainder bit 0 is stored into path[k], where k is the state index.
REQ-018 A remainder greater than 1 in any step SHALL set the error flag.
- The flag is sticky until the next accept.
- Decoding still completes; path[k] takes remainder bit 0.
REQ-019 Division SHALL be exact unsigned integer division on 32 bits, with no overflow possible, and the quotient SHALL be less than or equal to the dividend.
REQ-020 After S3 the FSM SHALL enter DONE and drive the outputs.
- `out_valid` = 1.
- `out_root` = final quotient.
- `out_path` and `out_err` = accumulated values.
REQ-021 Latency SHALL be fixed: `out_valid` rises on the 5th rising edge after the accept edge.
REQ-022 In DONE, the outputs SHALL hold stable while `out_ready` is 0, with no timeout.
REQ-023 In DONE with `out_ready` = 1, the FSM SHALL return to IDLE at that edge.
- `out_valid` falls.
- `in_ready` rises the following cycle; there is no same-cycle re-accept.
REQ-024 `out_root`, `out_path` and `out_err` SHALL hold their last values outside DONE; they are don't-care while `out_valid` is 0.

Reset
REQ-025 `rst` high at a rising edge SHALL force:
- FSM to IDLE;
- `in_ready` = 1 and `out_valid` = 0;
- `out_root` = 0, `out_path` = 0, `out_err` = 0.
REQ-026 Reset SHALL take priority over every handshake, including an accept or a consume in the same cycle.
REQ-027 Reset asserted in any of S0..S3 or DONE SHALL discard the in-flight decode with no output pulse.
REQ-028 The first accept after reset release SHALL be possible in the first cycle with `rst` low.

Verification
REQ-029 The bench SHALL cover: leaf 33 -> `out_root` = 0, `out_path` = 4'b1111, `out_err` = 0, with `out_valid` exactly 5 edges after the accept.
REQ-030 The bench SHALL cover: leaf 96 -> `out_root` = 1, `out_path` = 4'b0000, `out_err` = 0; and leaf 2 -> `out_root` = 0, `out_path` = 4'b0010, `out_err` = 0.
REQ-031 The bench SHALL cover: leaf 4 -> the S1 remainder is 2, giving `out_err` = 1, `out_root` = 0, `out_path` = 4'b0000.
REQ-032 The bench SHALL cover: leaf 0xFFFFFFFF -> the S2 remainder is 2, giving `out_err` = 1, `out_root` = 44739242, `out_path` = 4'b0011.
REQ-033 The bench SHALL cover: `out_ready` held 0 for 10 cycles in DONE -> outputs stable and `in_ready` = 0 throughout; `in_valid` pulses during that time are ignored.
REQ-034 The bench SHALL cover: `rst` pulsed during S2 -> no `out_valid`, all outputs 0, and a new leaf accepted in the first cycle after release decodes correctly.
